// File: rtl/updown_counter_mod_pkg.sv
// ============================================================================
// Module  : updown_counter_mod_pkg
// Purpose : Shared mode constants and parameter legality check for the counter
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package updown_counter_mod_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Legal when the modulus fits in the counter width and leaves at least two states.
    function automatic bit modulus_ok(input int width, input longint modulus);
        return (width >= 1) && (width <= 32) && (modulus >= 2) &&
               ($clog2(modulus) <= width);
    endfunction

endpackage

`default_nettype wire

// File: rtl/updown_counter_mod_if.sv
// ============================================================================
// Module  : updown_counter_mod_if
// Purpose : Control and status bundle between a counter and its user
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface updown_counter_mod_if #(
    parameter int WIDTH = 4
) ();

    logic             en;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             up;
    logic             down;
    logic [WIDTH-1:0] count;
    logic             carry;
    logic             borrow;
    logic             ovf;

    modport master (
        output en, clr, load, load_val, up, down,
        input  count, carry, borrow, ovf
    );

    modport slave (
        input  en, clr, load, load_val, up, down,
        output count, carry, borrow, ovf
    );

endinterface

`default_nettype wire

// File: rtl/updown_counter_mod.sv
// ============================================================================
// Module  : updown_counter_mod
// Purpose : Up/down counter with programmable modulus, load, clear, wrap or
//           saturate mode, carry/borrow for chaining and a sticky overflow flag
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module updown_counter_mod
    import updown_counter_mod_pkg::*;
#(
    parameter int     WIDTH   = 4,
    parameter longint MODULUS = 16,
    parameter int     MODE    = MODE_WRAP
) (
    input  logic                 clk,
    input  logic                 rstn,
    updown_counter_mod_if.slave  bus
);

    localparam logic [WIDTH-1:0] c_term = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_one  = WIDTH'(1);

    if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
        $error("updown_counter_mod: MODULUS out of range for WIDTH");
    end

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             ovf_q;
    logic             ovf_d;

    logic w_inc;
    logic w_dec;
    logic w_at_top;
    logic w_at_zero;
    logic w_carry;
    logic w_borrow;

    assign w_inc     = bus.en & bus.up & ~bus.down;
    assign w_dec     = bus.en & bus.down & ~bus.up;
    assign w_at_top  = (count_q == c_term);
    assign w_at_zero = (count_q == '0);
    // Carry/borrow are raised regardless of MODE so a downstream stage can chain on them.
    assign w_carry   = w_inc & w_at_top;
    assign w_borrow  = w_dec & w_at_zero;

    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (bus.clr) begin
            count_d = '0;
            ovf_d   = 1'b0;
        end else if (bus.load) begin
            count_d = (bus.load_val > c_term) ? c_term : bus.load_val;
        end else begin
            if (w_carry || w_borrow) begin
                ovf_d = 1'b1;
            end
            if (w_inc) begin
                if (w_at_top) begin
                    count_d = (MODE == MODE_SAT) ? count_q : '0;
                end else begin
                    count_d = count_q + c_one;
                end
            end else if (w_dec) begin
                if (w_at_zero) begin
                    count_d = (MODE == MODE_SAT) ? count_q : c_term;
                end else begin
                    count_d = count_q - c_one;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.count  = count_q;
    assign bus.ovf    = ovf_q;
    assign bus.carry  = w_carry;
    assign bus.borrow = w_borrow;

endmodule

`default_nettype wire

// File: tb/tb_updown_counter_mod.sv
// ============================================================================
// Module  : tb_updown_counter_mod
// Purpose : Self-checking bench driving three counter configurations in lockstep
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_updown_counter_mod;
    import updown_counter_mod_pkg::*;

    logic       clk = 1'b0;
    logic       rstn;
    logic       en, clr, load, up, down;
    logic [3:0] load_val;

    always #5 clk = ~clk;

    // dut0: mod 16 wrap, dut1: mod 10 wrap, dut2: mod 10 saturate
    updown_counter_mod_if #(.WIDTH(4)) bus0 ();
    updown_counter_mod_if #(.WIDTH(4)) bus1 ();
    updown_counter_mod_if #(.WIDTH(4)) bus2 ();

    assign bus0.en = en;  assign bus0.clr = clr;  assign bus0.load = load;
    assign bus0.up = up;  assign bus0.down = down; assign bus0.load_val = load_val;
    assign bus1.en = en;  assign bus1.clr = clr;  assign bus1.load = load;
    assign bus1.up = up;  assign bus1.down = down; assign bus1.load_val = load_val;
    assign bus2.en = en;  assign bus2.clr = clr;  assign bus2.load = load;
    assign bus2.up = up;  assign bus2.down = down; assign bus2.load_val = load_val;

    updown_counter_mod #(.WIDTH(4), .MODULUS(16), .MODE(MODE_WRAP)) u_dut0 (
        .clk(clk), .rstn(rstn), .bus(bus0.slave));
    updown_counter_mod #(.WIDTH(4), .MODULUS(10), .MODE(MODE_WRAP)) u_dut1 (
        .clk(clk), .rstn(rstn), .bus(bus1.slave));
    updown_counter_mod #(.WIDTH(4), .MODULUS(10), .MODE(MODE_SAT)) u_dut2 (
        .clk(clk), .rstn(rstn), .bus(bus2.slave));

    logic [2:0][3:0] o_cnt;
    logic [2:0]      o_ovf, o_carry, o_borrow;
    assign o_cnt    = {bus2.count, bus1.count, bus0.count};
    assign o_ovf    = {bus2.ovf, bus1.ovf, bus0.ovf};
    assign o_carry  = {bus2.carry, bus1.carry, bus0.carry};
    assign o_borrow = {bus2.borrow, bus1.borrow, bus0.borrow};

    typedef struct packed {
        logic [2:0][3:0] cnt;
        logic [2:0]      ovf;
        logic [2:0]      carry;
        logic [2:0]      borrow;
    } exp_t;

    exp_t sb[$];
    exp_t obs;
    exp_t e;

    int m_cnt  [3];
    bit m_ovf  [3];
    int mod_of [3] = '{16, 10, 10};
    bit sat_of [3] = '{1'b0, 1'b0, 1'b1};

    int n_run  = 0;
    int n_fail = 0;

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0;
            m_ovf[k] = 1'b0;
        end
    endtask

    // One clock of stimulus: predict, push the expectation, then capture the DUT.
    task automatic drive(input logic i_en, input logic i_clr, input logic i_load,
                         input logic i_up, input logic i_down, input logic [3:0] i_lv);
        exp_t x;
        bit   inc, dec;
        en = i_en; clr = i_clr; load = i_load; up = i_up; down = i_down; load_val = i_lv;
        inc = i_en && i_up && !i_down;
        dec = i_en && i_down && !i_up;
        @(negedge clk);
        obs.carry  = o_carry;
        obs.borrow = o_borrow;
        for (int k = 0; k < 3; k++) begin
            x.carry[k]  = inc && (m_cnt[k] == mod_of[k] - 1);
            x.borrow[k] = dec && (m_cnt[k] == 0);
            if (i_clr) begin
                m_cnt[k] = 0;
                m_ovf[k] = 1'b0;
            end else if (i_load) begin
                m_cnt[k] = (int'(i_lv) > mod_of[k] - 1) ? mod_of[k] - 1 : int'(i_lv);
            end else begin
                if (x.carry[k] || x.borrow[k]) m_ovf[k] = 1'b1;
                if (inc)
                    m_cnt[k] = sat_of[k] ? ((m_cnt[k] + 1 > mod_of[k] - 1) ? mod_of[k] - 1 : m_cnt[k] + 1)
                                         : (m_cnt[k] + 1) % mod_of[k];
                else if (dec)
                    m_cnt[k] = sat_of[k] ? ((m_cnt[k] == 0) ? 0 : m_cnt[k] - 1)
                                         : (m_cnt[k] + mod_of[k] - 1) % mod_of[k];
            end
            x.cnt[k] = 4'(m_cnt[k]);
            x.ovf[k] = m_ovf[k];
        end
        sb.push_back(x);
        @(posedge clk);
        #1;
        obs.cnt = o_cnt;
        obs.ovf = o_ovf;
        en = 1'b0; clr = 1'b0; load = 1'b0; up = 1'b0; down = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        en = 1'b0; clr = 1'b0; load = 1'b0; up = 1'b0; down = 1'b0; load_val = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_run++;
        if (o_cnt !== 12'h000) begin n_fail++; $display("FAIL reset count: got %h exp 000", o_cnt); end
        n_run++;
        if (o_ovf !== 3'b000) begin n_fail++; $display("FAIL reset ovf: got %b exp 000", o_ovf); end
        n_run++;
        if ({o_carry, o_borrow} !== 6'b0) begin
            n_fail++; $display("FAIL reset carry/borrow: got %b exp 000000", {o_carry, o_borrow});
        end
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_count_up();
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 0, 1, 0, 4'd0);
            e = sb.pop_front();
            n_run++; if (obs.cnt    !== e.cnt)    begin n_fail++; $display("FAIL up[%0d] count: got %h exp %h", i, obs.cnt, e.cnt); end
            n_run++; if (obs.ovf    !== e.ovf)    begin n_fail++; $display("FAIL up[%0d] ovf: got %b exp %b", i, obs.ovf, e.ovf); end
            n_run++; if (obs.carry  !== e.carry)  begin n_fail++; $display("FAIL up[%0d] carry: got %b exp %b", i, obs.carry, e.carry); end
            n_run++; if (obs.borrow !== e.borrow) begin n_fail++; $display("FAIL up[%0d] borrow: got %b exp %b", i, obs.borrow, e.borrow); end
        end
        n_run++;
        if (bus0.count !== 4'd0 || bus0.ovf !== 1'b1) begin
            n_fail++; $display("FAIL up16 dut0 wrap: got count %0d ovf %b exp 0 1", bus0.count, bus0.ovf);
        end
    endtask

    task automatic test_wrap_down_up();
        logic [5:0] steps [3];
        steps[0] = 6'b010000;
        steps[1] = 6'b100010;
        steps[2] = 6'b100100;
        for (int i = 0; i < 3; i++) begin
            drive(steps[i][5], steps[i][4], 0, steps[i][2], steps[i][1], 4'd0);
            e = sb.pop_front();
            n_run++; if (obs.cnt    !== e.cnt)    begin n_fail++; $display("FAIL wrap[%0d] count: got %h exp %h", i, obs.cnt, e.cnt); end
            n_run++; if (obs.ovf    !== e.ovf)    begin n_fail++; $display("FAIL wrap[%0d] ovf: got %b exp %b", i, obs.ovf, e.ovf); end
            n_run++; if (obs.carry  !== e.carry)  begin n_fail++; $display("FAIL wrap[%0d] carry: got %b exp %b", i, obs.carry, e.carry); end
            n_run++; if (obs.borrow !== e.borrow) begin n_fail++; $display("FAIL wrap[%0d] borrow: got %b exp %b", i, obs.borrow, e.borrow); end
        end
        n_run++;
        if (bus1.count !== 4'd0) begin n_fail++; $display("FAIL wrap dut1 9->0: got %0d exp 0", bus1.count); end
    endtask

    task automatic test_saturate();
        drive(0, 1, 0, 0, 0, 4'd0);
        void'(sb.pop_front());
        for (int i = 0; i < 14; i++) begin
            if (i < 12) drive(1, 0, 0, 1, 0, 4'd0);
            else        drive(1, 0, 0, 0, 1, 4'd0);
            if (i == 11) begin
                n_run++;
                if (bus2.count !== 4'd9 || bus2.ovf !== 1'b1) begin
                    n_fail++; $display("FAIL sat dut2 hold: got count %0d ovf %b exp 9 1", bus2.count, bus2.ovf);
                end
                drive(0, 1, 0, 0, 0, 4'd0);
                void'(sb.pop_front());
            end
            e = sb.pop_front();
            n_run++; if (obs.cnt    !== e.cnt)    begin n_fail++; $display("FAIL sat[%0d] count: got %h exp %h", i, obs.cnt, e.cnt); end
            n_run++; if (obs.ovf    !== e.ovf)    begin n_fail++; $display("FAIL sat[%0d] ovf: got %b exp %b", i, obs.ovf, e.ovf); end
            n_run++; if (obs.carry  !== e.carry)  begin n_fail++; $display("FAIL sat[%0d] carry: got %b exp %b", i, obs.carry, e.carry); end
            n_run++; if (obs.borrow !== e.borrow) begin n_fail++; $display("FAIL sat[%0d] borrow: got %b exp %b", i, obs.borrow, e.borrow); end
        end
    endtask

    task automatic test_load();
        drive(0, 1, 0, 0, 0, 4'd0);
        void'(sb.pop_front());
        for (int i = 0; i < 2; i++) begin
            if (i == 0) drive(0, 0, 1, 0, 0, 4'd12);
            else        drive(1, 0, 1, 1, 0, 4'd3);
            e = sb.pop_front();
            n_run++; if (obs.cnt    !== e.cnt)    begin n_fail++; $display("FAIL load[%0d] count: got %h exp %h", i, obs.cnt, e.cnt); end
            n_run++; if (obs.ovf    !== e.ovf)    begin n_fail++; $display("FAIL load[%0d] ovf: got %b exp %b", i, obs.ovf, e.ovf); end
            n_run++; if (obs.carry  !== e.carry)  begin n_fail++; $display("FAIL load[%0d] carry: got %b exp %b", i, obs.carry, e.carry); end
            n_run++; if (obs.borrow !== e.borrow) begin n_fail++; $display("FAIL load[%0d] borrow: got %b exp %b", i, obs.borrow, e.borrow); end
        end
    endtask

    task automatic test_hold();
        logic [5:0] steps [5];
        steps[0] = 6'b001000;  // load 9
        steps[1] = 6'b000100;  // en low, up
        steps[2] = 6'b100110;  // up and down
        steps[3] = 6'b010000;  // clear
        steps[4] = 6'b100110;  // up and down at zero
        for (int i = 0; i < 5; i++) begin
            drive(steps[i][5], steps[i][4], steps[i][3], steps[i][2], steps[i][1], 4'd9);
            e = sb.pop_front();
            n_run++; if (obs.cnt    !== e.cnt)    begin n_fail++; $display("FAIL hold[%0d] count: got %h exp %h", i, obs.cnt, e.cnt); end
            n_run++; if (obs.ovf    !== e.ovf)    begin n_fail++; $display("FAIL hold[%0d] ovf: got %b exp %b", i, obs.ovf, e.ovf); end
            n_run++; if (obs.carry  !== e.carry)  begin n_fail++; $display("FAIL hold[%0d] carry: got %b exp %b", i, obs.carry, e.carry); end
            n_run++; if (obs.borrow !== e.borrow) begin n_fail++; $display("FAIL hold[%0d] borrow: got %b exp %b", i, obs.borrow, e.borrow); end
        end
    endtask

    task automatic test_clr_load();
        drive(1, 0, 0, 0, 1, 4'd0);
        void'(sb.pop_front());
        drive(1, 1, 1, 1, 0, 4'd5);
        e = sb.pop_front();
        n_run++; if (obs.cnt !== e.cnt) begin n_fail++; $display("FAIL clrload count: got %h exp %h", obs.cnt, e.cnt); end
        n_run++; if (obs.ovf !== e.ovf) begin n_fail++; $display("FAIL clrload ovf: got %b exp %b", obs.ovf, e.ovf); end
    endtask

    task automatic test_async_reset();
        drive(1, 0, 0, 0, 1, 4'd0);
        void'(sb.pop_front());
        drive(0, 0, 1, 0, 0, 4'd5);
        void'(sb.pop_front());
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 1, 0, 4'd0);
            e = sb.pop_front();
            n_run++; if (obs.cnt !== e.cnt) begin n_fail++; $display("FAIL arst_pre[%0d] count: got %h exp %h", i, obs.cnt, e.cnt); end
            n_run++; if (obs.ovf !== e.ovf) begin n_fail++; $display("FAIL arst_pre[%0d] ovf: got %b exp %b", i, obs.ovf, e.ovf); end
        end
        en = 1'b1; up = 1'b1;
        #2;
        rstn = 1'b0;
        #1;
        n_run++;
        if (o_cnt !== 12'h000) begin n_fail++; $display("FAIL arst count: got %h exp 000", o_cnt); end
        n_run++;
        if (o_ovf !== 3'b000) begin n_fail++; $display("FAIL arst ovf: got %b exp 000", o_ovf); end
        en = 1'b0; up = 1'b0;
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_count_up();
        test_wrap_down_up();
        test_saturate();
        test_load();
        test_hold();
        test_clr_load();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
